// File: rtl/kanade32_mem_arbiter_if.sv
// Requester-side bus of the KANADE32 main-memory arbiter.
// All three masters share one bundle. Per-port fields are packed side by side,
// with port i in slice i.
interface kanade32_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;

  // The masters drive requests and observe the handshake.
  modport master (
    output req, we, addr, wdata,
    input  gnt, ack, rdata
  );

  // The arbiter observes requests and drives the handshake.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/kanade32_mem_arbiter.sv
// KANADE32 main-memory arbiter.
// Three masters share the single-port memory: 0 = video fetch, 1 = CPU ifetch,
// 2 = CPU load/store. One transaction is in flight at a time.
// Video has fixed priority, but an anti-starvation counter forces one CPU grant
// after MAX_STARVE consecutive video wins while a CPU port waits. The two CPU
// ports alternate round-robin.
// Timing: a request sampled in IDLE gives gnt and mem_en one cycle later. ack
// follows MEM_LAT+1 cycles after gnt. Every output is registered.
module kanade32_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  kanade32_mem_arbiter_if.slave bus,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int WW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [WW-1:0] LAT_LAST   = WW'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;      // cycles spent in ACCESS since mem_en
  logic [SW-1:0]   starve_q, starve_d;  // consecutive video wins over a waiting CPU
  logic            rr_q, rr_d;          // 0: port 1 preferred, 1: port 2 preferred
  logic [2:0]      win_q, win_d;        // one-hot owner of the current transaction
  logic            we_q, we_d;          // current transaction is a write
  logic [2:0]      gnt_q, gnt_d;
  logic [2:0]      ack_q, ack_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [1:0]      cpu_req;
  logic            video_masked;
  logic [1:0]      pick;
  logic [2:0]      pick_oh;
  logic [AW-1:0]   pick_addr;
  logic [DW-1:0]   pick_wdata;
  logic            pick_we;

  // Arbitration: choose this cycle's winner among the live requests.
  always_comb begin
    cpu_req      = bus.req[2:1];
    video_masked = (starve_q == STARVE_MAX) && (cpu_req != 2'b00);
    if (bus.req[0] && !video_masked) begin
      pick = 2'd0;
    end else if (!rr_q) begin
      pick = cpu_req[0] ? 2'd1 : 2'd2;
    end else begin
      pick = cpu_req[1] ? 2'd2 : 2'd1;
    end
    pick_oh    = 3'b001 << pick;
    pick_addr  = bus.addr[int'(pick)*AW +: AW];
    pick_wdata = bus.wdata[int'(pick)*DW +: DW];
    pick_we    = bus.we[pick];
  end

  // Next-state and next-output logic for the IDLE -> ACCESS -> RESP sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case. A path that leaves
    // one unassigned would infer a latch.
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    rr_d        = rr_q;
    win_d       = win_q;
    we_d        = we_q;
    gnt_d       = 3'b000;
    ack_d       = 3'b000;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req != 3'b000) begin
          win_d       = pick_oh;
          we_d        = pick_we;
          gnt_d       = pick_oh;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_we;
          mem_addr_d  = pick_addr;
          mem_wdata_d = pick_wdata;
          wait_d      = '0;
          state_d     = ACCESS;
          if (pick == 2'd0) begin
            if ((cpu_req != 2'b00) && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            starve_d = '0;
            rr_d     = (pick == 2'd1);
          end
        end
      end

      ACCESS: begin
        // mem_rdata is valid in the cycle where the counter reaches MEM_LAT.
        if (wait_q == LAT_LAST) begin
          ack_d   = win_q;
          state_d = RESP;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. A reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Blocking
    // assignments here would create order-dependent simulation races.
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      rr_q        <= 1'b0;
      win_q       <= 3'b000;
      we_q        <= 1'b0;
      gnt_q       <= 3'b000;
      ack_q       <= 3'b000;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
